// File: rtl/cpu_ctrl_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer: bus IDs, class codes,
// state encodings and the control-bus payload.
package cpu_ctrl_sequencer_pkg;

   localparam int unsigned ID_W   = 5;
   localparam int unsigned OPC_W  = 5;
   localparam int unsigned AMID_W = 2;
   localparam int unsigned CLS_W  = 3;
   localparam int unsigned ST_W   = 4;

   localparam logic [ID_W-1:0] ID_IR0 = ID_W'(0);
   localparam logic [ID_W-1:0] ID_IR1 = ID_W'(1);
   localparam logic [ID_W-1:0] ID_ACC = ID_W'(2);
   localparam logic [ID_W-1:0] ID_B   = ID_W'(3);
   localparam logic [ID_W-1:0] ID_MEM = ID_W'(4);
   localparam logic [ID_W-1:0] ID_ALU = ID_W'(5);

   localparam logic [AMID_W-1:0] AMID_PC = AMID_W'(0);
   localparam logic [AMID_W-1:0] AMID_IR = AMID_W'(1);

   typedef enum logic [CLS_W-1:0] {
      CLS_NOP   = 3'b000,
      CLS_MOV   = 3'b001,
      CLS_LOAD  = 3'b010,
      CLS_STORE = 3'b011,
      CLS_ALU   = 3'b100,
      CLS_RSV5  = 3'b101,
      CLS_RSV6  = 3'b110,
      CLS_HLT   = 3'b111
   } cls_e;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 4'd0,
      ST_F0   = 4'd1,
      ST_F1   = 4'd2,
      ST_F2   = 4'd3,
      ST_F3   = 4'd4,
      ST_F4   = 4'd5,
      ST_DEC  = 4'd6,
      ST_EX0  = 4'd7,
      ST_EX1  = 4'd8,
      ST_EX2  = 4'd9,
      ST_HALT = 4'd10
   } state_e;

   typedef struct packed {
      logic [OPC_W-1:0]  alu_opcode;
      logic [ID_W-1:0]   mid;
      logic [ID_W-1:0]   sid;
      logic [AMID_W-1:0] amid;
      logic              pc_inr;
      logic              mid_en;
      logic              sid_en;
      logic              halted;
      logic              illegal;
   } ctrl_bus_t;

   function automatic logic is_reserved(input cls_e c);
      return (c == CLS_RSV5) || (c == CLS_RSV6);
   endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational Moore decode of {state, class, operands} onto the control bus.
module cpu_ctrl_decode
   import cpu_ctrl_sequencer_pkg::*;
(
   input  logic [ST_W-1:0]  state,
   input  logic [CLS_W-1:0] cls,
   input  logic [ID_W-1:0]  opa,
   input  logic [ID_W-1:0]  opb,
   output ctrl_bus_t        bus
);

   state_e st;
   cls_e   c;

   assign st = state_e'(state);
   assign c  = cls_e'(cls);

   always_comb begin
      bus = '0;
      case (st)
         ST_F0: begin
            bus.amid   = AMID_PC;
            bus.mid    = ID_MEM;
            bus.mid_en = 1'b1;
         end
         ST_F1: begin
            bus.amid   = AMID_PC;
            bus.mid    = ID_MEM;
            bus.mid_en = 1'b1;
            bus.sid    = ID_IR0;
            bus.sid_en = 1'b1;
            bus.pc_inr = 1'b1;
         end
         ST_F2: begin
            bus.amid   = AMID_PC;
            bus.mid    = ID_MEM;
            bus.mid_en = 1'b1;
            bus.sid    = ID_IR0;
         end
         ST_F3: begin
            bus.amid   = AMID_PC;
            bus.mid    = ID_MEM;
            bus.mid_en = 1'b1;
            bus.sid    = ID_IR1;
            bus.sid_en = 1'b1;
            bus.pc_inr = 1'b1;
         end
         ST_DEC: bus.illegal = is_reserved(c);
         ST_EX0, ST_EX1, ST_EX2: begin
            case (c)
               CLS_MOV: begin
                  bus.amid = AMID_PC;
                  bus.mid  = opa;
                  bus.sid  = opb;
               end
               CLS_LOAD: begin
                  bus.amid = AMID_IR;
                  bus.mid  = ID_MEM;
                  bus.sid  = opa;
               end
               CLS_STORE: begin
                  bus.amid = AMID_IR;
                  bus.mid  = opa;
                  bus.sid  = ID_MEM;
               end
               CLS_ALU: begin
                  bus.alu_opcode = OPC_W'(opa);
                  bus.mid        = ID_ALU;
                  bus.sid        = ID_ACC;
               end
               default: ;
            endcase
            // EX2 is a settle cycle: enables drop, operand fields stay put
            bus.mid_en = (st != ST_EX2);
            bus.sid_en = (st == ST_EX1);
         end
         ST_HALT: bus.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the datapath control bus.
// State advances on the falling clock edge so the bus is stable at rising edges.
module cpu_ctrl_sequencer
   import cpu_ctrl_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ir0,
   input  logic [7:0] ir1,
   output logic [4:0] alu_opcode,
   output logic [4:0] mid,
   output logic [4:0] sid,
   output logic [1:0] amid,
   output logic       pc_inr,
   output logic       mid_en,
   output logic       sid_en,
   output logic       halted,
   output logic       illegal,
   output logic [3:0] t_state
);

   state_e            state_q, state_d;
   cls_e              cls_q, cls_d;
   logic [ID_W-1:0]   opa_q, opa_d;
   logic [ID_W-1:0]   opb_q, opb_d;
   ctrl_bus_t         bus_q, bus_d;
   logic              unused_ir1;

   assign unused_ir1 = ^ir1[7:5];

   // Next state; instruction fields are captured on entry to DEC
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      case (state_q)
         ST_IDLE: state_d = ST_F0;
         ST_F0:   state_d = ST_F1;
         ST_F1:   state_d = ST_F2;
         ST_F2:   state_d = ST_F3;
         ST_F3:   state_d = ST_F4;
         ST_F4: begin
            state_d = ST_DEC;
            cls_d   = cls_e'(ir0[7:5]);
            opa_d   = ir0[4:0];
            opb_d   = ir1[4:0];
         end
         ST_DEC: begin
            case (cls_q)
               CLS_NOP, CLS_RSV5, CLS_RSV6: state_d = ST_F0;
               CLS_HLT:                     state_d = ST_HALT;
               default:                     state_d = ST_EX0;
            endcase
         end
         ST_EX0:  state_d = ST_EX1;
         ST_EX1:  state_d = ST_EX2;
         ST_EX2:  state_d = ST_F0;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Decoding the next state lets the bus register track the state register
   cpu_ctrl_decode u_decode (
      .state (state_d),
      .cls   (cls_d),
      .opa   (opa_d),
      .opb   (opb_d),
      .bus   (bus_d)
   );

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cls_q   <= CLS_NOP;
         opa_q   <= '0;
         opb_q   <= '0;
         bus_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         bus_q   <= bus_d;
      end
   end

   assign alu_opcode = bus_q.alu_opcode;
   assign mid        = bus_q.mid;
   assign sid        = bus_q.sid;
   assign amid       = bus_q.amid;
   assign pc_inr     = bus_q.pc_inr;
   assign mid_en     = bus_q.mid_en;
   assign sid_en     = bus_q.sid_en;
   assign halted     = bus_q.halted;
   assign illegal    = bus_q.illegal;
   assign t_state    = state_q;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Directed, table-driven bench for cpu_ctrl_sequencer: one expected row per cycle.
module tb_cpu_ctrl_sequencer;

   logic       clk;
   logic       reset;
   logic [7:0] ir0, ir1;
   logic [4:0] alu_opcode, mid, sid;
   logic [1:0] amid;
   logic       pc_inr, mid_en, sid_en, halted, illegal;
   logic [3:0] t_state;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] ir0;
      logic [7:0] ir1;
      logic [3:0] st;
      logic [4:0] opc;
      logic [4:0] mid;
      logic [4:0] sid;
      logic [1:0] amid;
      logic       pc;
      logic       me;
      logic       se;
      logic       hl;
      logic       il;
      logic       full;
   } vec_t;

   vec_t vq[$];

   cpu_ctrl_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .ir0        (ir0),
      .ir1        (ir1),
      .alu_opcode (alu_opcode),
      .mid        (mid),
      .sid        (sid),
      .amid       (amid),
      .pc_inr     (pc_inr),
      .mid_en     (mid_en),
      .sid_en     (sid_en),
      .halted     (halted),
      .illegal    (illegal),
      .t_state    (t_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input int st, opc, m, s, am, pc, me, se, hl, il, full);
      vec_t v;
      v.ir0  = 8'h00;
      v.ir1  = 8'h00;
      v.st   = 4'(st);
      v.opc  = 5'(opc);
      v.mid  = 5'(m);
      v.sid  = 5'(s);
      v.amid = 2'(am);
      v.pc   = 1'(pc);
      v.me   = 1'(me);
      v.se   = 1'(se);
      v.hl   = 1'(hl);
      v.il   = 1'(il);
      v.full = 1'(full);
      return v;
   endfunction

   task automatic add_row(input logic [7:0] a, b,
                          input int st, opc, m, s, am, pc, me, se, hl, il, full);
      vec_t v;
      v = mk(st, opc, m, s, am, pc, me, se, hl, il, full);
      v.ir0 = a;
      v.ir1 = b;
      vq.push_back(v);
   endtask

   // F0..F4 with fixed fetch bus pattern (MEM=4, IR0=0, IR1=1)
   task automatic push_fetch(input logic [7:0] a, b);
      add_row(a, b, 1, 0, 4, 0, 0, 0, 1, 0, 0, 0, 1);
      add_row(a, b, 2, 0, 4, 0, 0, 1, 1, 1, 0, 0, 1);
      add_row(a, b, 3, 0, 4, 0, 0, 0, 1, 0, 0, 0, 1);
      add_row(a, b, 4, 0, 4, 1, 0, 1, 1, 1, 0, 0, 1);
      add_row(a, b, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic check(input string nm, input vec_t e);
      logic ok;
      ok = (t_state == e.st) && (alu_opcode == e.opc) && (pc_inr == e.pc) &&
           (mid_en == e.me) && (sid_en == e.se) && (halted == e.hl) && (illegal == e.il);
      if (e.full) ok = ok && (mid == e.mid) && (sid == e.sid) && (amid == e.amid);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got st=%0d opc=%0d mid=%0d sid=%0d amid=%0d pc=%b me=%b se=%b hl=%b il=%b; want st=%0d opc=%0d mid=%0d sid=%0d amid=%0d pc=%b me=%b se=%b hl=%b il=%b (bus fields %0s)",
                  nm, t_state, alu_opcode, mid, sid, amid, pc_inr, mid_en, sid_en, halted, illegal,
                  e.st, e.opc, e.mid, e.sid, e.amid, e.pc, e.me, e.se, e.hl, e.il,
                  e.full ? "checked" : "ignored");
      end
   endtask

   initial begin
      reset = 1'b0;
      ir0   = 8'h00;
      ir1   = 8'h00;

      // NOP: 6 cycles F0..DEC, then straight back to F0
      push_fetch(8'h00, 8'h00);
      add_row(8'h00, 8'h00, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      // MOV 1->3
      push_fetch(8'h21, 8'h03);
      add_row(8'h21, 8'h03, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add_row(8'h21, 8'h03, 7, 0, 1, 3, 0, 0, 1, 0, 0, 0, 1);
      add_row(8'h21, 8'h03, 8, 0, 1, 3, 0, 0, 1, 1, 0, 0, 1);
      add_row(8'h21, 8'h03, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // MOV 2->2, no special case
      push_fetch(8'h22, 8'h02);
      add_row(8'h22, 8'h02, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add_row(8'h22, 8'h02, 7, 0, 2, 2, 0, 0, 1, 0, 0, 0, 1);
      add_row(8'h22, 8'h02, 8, 0, 2, 2, 0, 0, 1, 1, 0, 0, 1);
      add_row(8'h22, 8'h02, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // LOAD to 2; ir garbage outside DEC must be ignored
      push_fetch(8'hE0, 8'hFF);
      add_row(8'h42, 8'h00, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add_row(8'h42, 8'h00, 7, 0, 4, 2, 1, 0, 1, 0, 0, 0, 1);
      add_row(8'hA0, 8'hFF, 8, 0, 4, 2, 1, 0, 1, 1, 0, 0, 1);
      add_row(8'hE0, 8'hFF, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // STORE from 2
      push_fetch(8'h62, 8'h00);
      add_row(8'h62, 8'h00, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add_row(8'h62, 8'h00, 7, 0, 2, 4, 1, 0, 1, 0, 0, 0, 1);
      add_row(8'hE0, 8'h00, 8, 0, 2, 4, 1, 0, 1, 1, 0, 0, 1);
      add_row(8'hE0, 8'h00, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // ALU op 5: opcode held EX0..EX2
      push_fetch(8'h85, 8'h00);
      add_row(8'h85, 8'h00, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add_row(8'h85, 8'h00, 7, 5, 5, 2, 0, 0, 1, 0, 0, 0, 1);
      add_row(8'h85, 8'h00, 8, 5, 5, 2, 0, 0, 1, 1, 0, 0, 1);
      add_row(8'h85, 8'h00, 9, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // NOP again: opcode must be back to 0 in F0
      push_fetch(8'h00, 8'h00);
      add_row(8'h00, 8'h00, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      // reserved classes 101 and 110
      push_fetch(8'hA0, 8'h00);
      add_row(8'hA0, 8'h00, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      push_fetch(8'hC0, 8'h00);
      add_row(8'hC0, 8'h00, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      // HLT, then 21 cycles parked in HALT regardless of ir
      push_fetch(8'hE0, 8'h00);
      add_row(8'hE0, 8'h00, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 21; k++)
         add_row(8'h21, 8'h03, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

      repeat (2) @(posedge clk);
      check("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         ir0 = vq[i].ir0;
         ir1 = vq[i].ir1;
         @(negedge clk);
         @(posedge clk);
         check($sformatf("row%0d", i), vq[i]);
      end

      // leave HALT via reset
      reset = 1'b0;
      #1 check("halt_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      ir0 = 8'h21;
      ir1 = 8'h03;
      @(posedge clk);
      reset = 1'b1;
      #1 check("idle_after_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      @(posedge clk);
      check("f0_after_halt", mk(1, 0, 4, 0, 0, 0, 1, 0, 0, 0, 1));

      // reset in EX1 of MOV
      repeat (7) @(negedge clk);
      @(posedge clk);
      check("mov_ex1_pre_reset", mk(8, 0, 1, 3, 0, 0, 1, 1, 0, 0, 1));
      #1 reset = 1'b0;
      #1 check("reset_in_ex1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      #1 reset = 1'b1;
      #1 check("idle_hold_after_ex1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      @(posedge clk);
      check("f0_after_ex1_reset", mk(1, 0, 4, 0, 0, 0, 1, 0, 0, 0, 1));
      @(negedge clk);
      @(posedge clk);
      check("f1_after_ex1_reset", mk(2, 0, 4, 0, 0, 1, 1, 1, 0, 0, 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
